// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a PicoRV32 native memory port; grant held until mem_ready; optional watchdog under MEM_ARBITER_TIMEOUT_EN.
// Latency: grant one cycle after request is sampled in IDLE; ready/rdata are combinational; an ungranted master sees ready low until served.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0__mem_valid,
    input  logic        m0__mem_instr,
    input  logic [31:0] m0__mem_addr,
    input  logic [31:0] m0__mem_wdata,
    input  logic [3:0]  m0__mem_wstrb,
    output logic        m0__mem_ready,
    output logic [31:0] m0__mem_rdata,

    input  logic        m1__mem_valid,
    input  logic        m1__mem_instr,
    input  logic [31:0] m1__mem_addr,
    input  logic [31:0] m1__mem_wdata,
    input  logic [3:0]  m1__mem_wstrb,
    output logic        m1__mem_ready,
    output logic [31:0] m1__mem_rdata,

    output logic        mem__mem_valid,
    output logic        mem__mem_instr,
    output logic [31:0] mem__mem_addr,
    output logic [31:0] mem__mem_wdata,
    output logic [3:0]  mem__mem_wstrb,
    input  logic        mem__mem_ready,
    input  logic [31:0] mem__mem_rdata,

    output logic [1:0]  grant,
    output logic        timeout_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic            last_nxt;
    logic [CW-1:0]   cnt;
    logic            in_grant;
    logic            sel1;
    logic            req_valid;
    logic            expire;
    logic            done;

    assign in_grant  = (state != IDLE);
    assign sel1      = (state == GRANT1);
    assign req_valid = sel1 ? m1__mem_valid : m0__mem_valid;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;

    // Counter is zero on the first grant cycle, so expiry lands on grant cycle TIMEOUT_CYCLES.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (!mem__mem_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_error <= 1'b0;
        end else if (expire) begin
            timeout_error <= 1'b1;
        end
    end
`else
    localparam bit TMO_EN = 1'b0;

    assign cnt           = '0;
    assign timeout_error = 1'b0;
`endif

    // A real ready in the expiry cycle wins; an already-aborted request does not expire.
    assign expire = TMO_EN && in_grant && req_valid && !mem__mem_ready && (cnt == LIMIT);
    assign done   = in_grant && (mem__mem_ready || expire);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0__mem_valid && (!m1__mem_valid || last)) begin
                    state_nxt = GRANT0;
                end else if (m1__mem_valid) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (done) begin
                    state_nxt = IDLE;
                    last_nxt  = sel1;
                end else if (!req_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem__mem_valid = 1'b0;
        mem__mem_instr = 1'b0;
        mem__mem_addr  = '0;
        mem__mem_wdata = '0;
        mem__mem_wstrb = '0;
        if (in_grant) begin
            mem__mem_valid = req_valid && !expire;
            mem__mem_instr = sel1 ? m1__mem_instr : m0__mem_instr;
            mem__mem_addr  = sel1 ? m1__mem_addr  : m0__mem_addr;
            mem__mem_wdata = sel1 ? m1__mem_wdata : m0__mem_wdata;
            mem__mem_wstrb = sel1 ? m1__mem_wstrb : m0__mem_wstrb;
        end
    end

    assign m0__mem_ready = done && (state == GRANT0);
    assign m1__mem_ready = done && (state == GRANT1);
    assign m0__mem_rdata = (expire && state == GRANT0) ? ERROR_DATA : mem__mem_rdata;
    assign m1__mem_rdata = (expire && state == GRANT1) ? ERROR_DATA : mem__mem_rdata;

    assign grant = {state == GRANT1, state == GRANT0};

endmodule
